// File: rtl/cache_drain_pkg.sv
// Shared types and constants for the data-cache drain sequencer.
package cache_drain_pkg;

  localparam logic [6:0] DRAIN_OPCODE = 7'h7f;
  localparam int         LINE_W       = 128;
  localparam int         CL_TAG_W     = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [CL_TAG_W-1:0] tag;
    logic [LINE_W-1:0]   data;
  } cache_line_t;

endpackage

// File: rtl/cache_drain_addr_gen.sv
// Walk index counter with last-line flag and {tag, idx, 4'b0} block address.
module cache_drain_addr_gen #(
  parameter int NUM_LINES = 4,
  parameter int INDEX_W   = 2,
  parameter int TAG_W     = 26,
  parameter int ADDR_W    = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  input  logic [TAG_W-1:0]   tag,
  output logic [INDEX_W-1:0] idx,
  output logic               last,
  output logic [ADDR_W-1:0]  addr
);
  import cache_drain_pkg::*;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + 1'b1;
    end
  end

  assign last = (idx == INDEX_W'(NUM_LINES - 1));
  assign addr = {tag, idx, 4'b0000};

endmodule

// File: rtl/cache_drain_ctrl.sv
// Writes every valid+dirty cache line back to memory on a drain request, stalling the pipeline meanwhile.
// Build option DRAIN_INVALIDATE_EN additionally invalidates every line visited by the walk.
module cache_drain_ctrl #(
  parameter int NUM_LINES = 4,
  parameter int INDEX_W   = 2,
  parameter int LINE_W    = 128,
  parameter int ADDR_W    = 32,
  parameter int TAG_W     = 26
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               drain_req,
  output logic               stall,
  output logic               drain_done,
  output logic [INDEX_W-1:0] line_idx,
  input  logic               line_valid,
  input  logic               line_dirty,
  input  logic [TAG_W-1:0]   line_tag,
  input  logic [LINE_W-1:0]  line_data,
  output logic               clr_dirty,
  output logic               clr_valid,
  output logic               mem_wr_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [LINE_W-1:0]  mem_wdata,
  input  logic               mem_ready
);
  import cache_drain_pkg::*;

  drain_state_t      state;
  drain_state_t      next_state;
  logic              idx_inc;
  logic              idx_clr;
  logic              last;
  logic              latch;
  logic [ADDR_W-1:0] blk_addr;

  cache_drain_addr_gen #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .clock (clock),
    .reset (reset),
    .clear (idx_clr),
    .inc   (idx_inc),
    .tag   (line_tag),
    .idx   (line_idx),
    .last  (last),
    .addr  (blk_addr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    idx_inc    = 1'b0;
    idx_clr    = 1'b0;
    latch      = 1'b0;
    clr_dirty  = 1'b0;
    clr_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (drain_req) next_state = SCAN;
      end
      SCAN: begin
        if (line_valid && line_dirty) begin
          latch      = 1'b1;
          next_state = WRITE;
        end else begin
`ifdef DRAIN_INVALIDATE_EN
          clr_valid = line_valid;
`endif
          if (last) next_state = DONE;
          else      idx_inc    = 1'b1;
        end
      end
      WRITE: begin
        // Acceptance is the only way out; address and data stay latched until then.
        if (mem_ready) begin
          clr_dirty = 1'b1;
`ifdef DRAIN_INVALIDATE_EN
          clr_valid = 1'b1;
`endif
          if (last) begin
            next_state = DONE;
          end else begin
            idx_inc    = 1'b1;
            next_state = SCAN;
          end
        end
      end
      DONE: begin
        idx_clr    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (latch) begin
      mem_addr  <= blk_addr;
      mem_wdata <= line_data;
    end
  end

  assign stall      = (state != IDLE);
  assign drain_done = (state == DONE);
  assign mem_wr_req = (state == WRITE);

endmodule

// File: doc/cache_drain_ctrl.md
Name: cache_drain_ctrl

Overview:
- Sequencer in the MEM stage, between the data-cache arrays and main memory.
- When the pipeline retires the drain instruction (opcode 7'h7f), the block walks every cache line and writes each valid+dirty line back to main memory as one 128-bit block.
- It clears each line's dirty bit after the write and stalls the pipeline until the walk completes.
- Benches depend on this block to make main-memory checks reflect cached stores.

Parameters:
- NUM_LINES, 4, number of direct-mapped cache lines (power of 2, ≥2).
- INDEX_W, 2, log2(NUM_LINES).
- LINE_W, 128, line width in bits (4 × 32-bit words).
- ADDR_W, 32, byte-address width.
- TAG_W, 26, tag width; ADDR_W = TAG_W + INDEX_W + 4.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- drain_req  in  1  one-cycle pulse from the MEM stage when the drain opcode is in MEM.
- stall  out  1  holds the whole pipeline while the block is not IDLE.
- drain_done  out  1  one-cycle pulse when the walk finishes.
- line_idx  out  INDEX_W  index driven to the cache tag and data arrays (combinational read).
- line_valid  in  1  valid bit of line_idx.
- line_dirty  in  1  dirty bit of line_idx.
- line_tag  in  TAG_W  tag of line_idx.
- line_data  in  LINE_W  data of line_idx.
- clr_dirty  out  1  clears the dirty bit of line_idx on this edge.
- clr_valid  out  1  clears the valid bit of line_idx (optional feature only; tied 0 otherwise).
- mem_wr_req  out  1  write request to main memory.
- mem_addr  out  ADDR_W  block-aligned byte address = {tag, idx, 4'b0}.
- mem_wdata  out  LINE_W  block being written.
- mem_ready  in  1  main memory accepts the write this cycle.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, index counter 0. Reset mid-walk aborts immediately; no drain_done is produced.
- IDLE:
  - drain_req → SCAN, with idx = 0 and stall = 1 from the next cycle.
  - drain_req in any other state is ignored.
- SCAN (one cycle per line):
  - If line_valid and line_dirty: latch tag and data into mem_addr/mem_wdata → WRITE.
  - Otherwise, if idx = NUM_LINES-1 → DONE; else idx++ and stay in SCAN.
- WRITE:
  - mem_wr_req = 1; mem_addr/mem_wdata are held stable until accepted.
  - On mem_ready: assert clr_dirty for that cycle and drop mem_wr_req the next cycle.
  - After acceptance, if idx = NUM_LINES-1 → DONE; else idx++ → SCAN.
  - mem_ready is only sampled while mem_wr_req = 1. A mem_ready in the same cycle as the request rise counts as acceptance, giving a minimum 1 cycle per write.
- DONE: drain_done = 1 and stall = 1 for exactly one cycle → IDLE.
- Latency:
  - Empty or clean cache: NUM_LINES + 1 cycles from drain_req to drain_done.
  - Each dirty line adds 1 + (mem_ready wait) cycles.
- Wrap-around: idx never wraps during a walk; the walk ends at NUM_LINES-1 and idx returns to 0 in IDLE.
- line_idx = idx in every state; in IDLE it is 0 so it does not disturb the normal cache access path (that path owns the arrays while stall = 0).
- clr_dirty and clr_valid are single-cycle pulses aligned to the accepting edge.

Optional Feature:
- Macro: DRAIN_INVALIDATE_EN.
- Defined:
  - clr_valid pulses alongside clr_dirty for dirty lines.
  - In SCAN, clean valid lines also get a one-cycle clr_valid.
  - After DONE the cache is entirely invalid, so the next load must miss to main memory.
- Undefined: clr_valid is tied 0 and lines remain valid and clean after the drain.

Decomposition:
- Shared package: drain_state_t enum (IDLE, SCAN, WRITE, DONE), DRAIN_OPCODE = 7'h7f, LINE_W, and a cache_line_t struct (valid, dirty, tag, data).
- Sub-module cache_drain_addr_gen: index counter with last-line flag and {tag, idx, 4'b0} address composition.
- FSM and handshake stay in the top.

Test Plan:
- Clean cache, drain_req pulse:
  - no mem_wr_req;
  - drain_done exactly 5 cycles after drain_req;
  - stall high for those 5 cycles.
- Line 0 tag 0 dirty with data {0,0,10,5}, line 1 tag 0 dirty holding 12 at word 0, mem_ready tied 1:
  - two writes, to mem_addr 0x0 and 0x10 with the matching data;
  - clr_dirty pulses for idx 0 and idx 1;
  - drain_done after 7 cycles.
- Dirty line 3 with tag 0x1, mem_ready delayed 3 cycles:
  - mem_addr = 0x70, held with mem_wdata stable over the 4-cycle wait;
  - exactly one clr_dirty pulse.
- Reset asserted during WRITE:
  - mem_wr_req, stall and clr_dirty drop asynchronously to 0;
  - no drain_done;
  - a subsequent drain_req restarts at idx 0.
- drain_req pulsed again during SCAN: ignored; only one drain_done.
- DRAIN_INVALIDATE_EN defined, lines 0 (dirty) and 2 (valid, clean): clr_valid pulses on idx 0 and idx 2, and only line 0 is written to memory.
